axi2hdmi_frame_sink: RTL and testbench
======================================

Name: axi2hdmi_frame_sink

Overview:
Simulation/verification sink for the SoC's axi2hdmi video output (hsync, vsync, 8-bit R/G/B). It recovers raster timing from the sync pulses and extracts the active window. Per frame it reports a pixel signature plus the measured line and frame totals. It is instantiated in the Cheshire fixture beside the VIP so benches can self-check framebuffer output without a pixel-dump file.

Parameters:
SyncActiveHigh, 1, 1: sync asserted when high; 0: asserted when low
CntWidth, 16, width of h/v counters and totals
HActStart, 144, samples from hsync leading edge (inclusive) to first active pixel
HActive, 640, active pixels per line
VActStart, 35, lines from vsync leading edge to first active line
VActive, 480, active lines per frame

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active low
pix_en_i  in  1  pixel strobe; all video inputs sampled only when high
hsync_i  in  1  horizontal sync
vsync_i  in  1  vertical sync
red_i / green_i / blue_i  in  8 each  pixel colour
clear_i  in  1  synchronous soft clear
frame_valid_o  out  1  one-cycle pulse: frame results updated
frame_sig_o  out  32  pixel signature of completed frame
h_total_o  out  CntWidth  samples per line (last line of frame)
v_total_o  out  CntWidth  lines in completed frame
frame_cnt_o  out  CntWidth  frames reported since reset/clear (wraps)
timing_err_o  out  1  sticky timing error

Behaviour:
- Reset (rst_ni low, async) or clear_i (sync; wins over everything else in that cycle): all outputs 0, state IDLE, counters 0, signature register at init value.
- Sample: a clk edge with pix_en_i=1. Leading edge = sync asserted now and not asserted at the previous sample. Sync history is updated only on samples.
- Counters: h_cnt resets to 0 on each hsync leading edge, otherwise +1 per sample. v_cnt resets to 0 on vsync leading edge, otherwise +1 per hsync leading edge.
- Coincident hsync+vsync edge: v_cnt=0 and h_cnt=0; that line is line 0 of the new frame.
- Active pixel: HActStart <= h_cnt < HActStart+HActive and VActStart <= v_cnt < VActStart+VActive, compared against the counters after that sample's edge processing. The vsync-edge sample belongs to the new frame.
- h_total: h_cnt+1 captured at each hsync edge. Mismatch against the previous line's value (after the first line of the frame) sets timing_err_o.
- v_total: number of hsync edges from one vsync edge (inclusive) to the next (exclusive).
- Saturation: any counter reaching all-ones saturates and sets timing_err_o.
- FSM:
  - IDLE: ignore pixels; on vsync edge go to FIRST and init the signature.
  - FIRST: accumulate; on next vsync edge report, go to RUN.
  - RUN: accumulate; on each vsync edge report. v_total differing from the previous report sets timing_err_o.
- Report: the clk cycle after the vsync-edge sample, frame_valid_o=1 for exactly one cycle. frame_sig_o, h_total_o and v_total_o update, frame_cnt_o increments. Outputs hold until the next report. The signature re-inits in the same cycle, including the vsync-edge pixel if active.
- timing_err_o clears only on reset or clear_i.
- pix_en_i low: no state change other than the report pulse.

Optional Feature:
Macro AXI2HDMI_FRAME_SINK_CRC_EN.
- Defined: signature is standard CRC-32 (IEEE, reflected poly 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF) over bytes R, G, B per active pixel in raster order.
- Undefined: signature is the sum mod 2^32 of zero-extended {R,G,B}, init 0; no CRC logic synthesised.

Decomposition:
- Package axi2hdmi_frame_sink_pkg: state enum (IDLE/FIRST/RUN), CRC poly/init/xorout constants.
- Sub-module axi2hdmi_frame_sink_crc24: combinational one-pixel (24-bit) CRC-32 update; present only under the macro.

Test Plan:
- Bench timing for all directed tests: HActStart=2, HActive=3, VActStart=1, VActive=1, 8 samples/line, 4 lines/frame, pix_en_i tied 1.
- Active pixels 0x313233, 0x343536, 0x373839 with CRC_EN -> frame_sig_o=0xCBF43926, h_total_o=8, v_total_o=4, frame_cnt_o increments once per frame. Without CRC_EN -> 0x009C9FA2.
- Single active pixel 0x000000 with CRC_EN (HActive=1) -> frame_sig_o=0xFF41D912.
- One line stretched to 9 samples mid-frame -> timing_err_o=1 and stays 1 across later clean frames; clear_i -> 0, state IDLE, frame_valid_o silent until two vsync edges have occurred.
- SyncActiveHigh=0 with inverted syncs and pix_en_i toggling every other cycle -> identical results to the first test; frame_valid_o pulses exactly one cycle after the vsync sample.
- rst_ni asserted mid-frame -> outputs 0 immediately. After release, the first report comes at the second vsync edge and carries no partial-frame data.

Source files
------------

// File: rtl/axi2hdmi_frame_sink_pkg.sv
// Shared types and constants for the axi2hdmi frame sink.
// The CRC constants are used only when AXI2HDMI_FRAME_SINK_CRC_EN is defined.
package axi2hdmi_frame_sink_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        RUN   = 2'd2
    } state_e;

    localparam logic [31:0] CRC_POLY   = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF;

endpackage

// File: rtl/axi2hdmi_frame_sink_crc24.sv
// One-pixel CRC-32 update (reflected IEEE), bytes R then G then B.
// Compiled only when AXI2HDMI_FRAME_SINK_CRC_EN is defined.
`ifdef AXI2HDMI_FRAME_SINK_CRC_EN
module axi2hdmi_frame_sink_crc24
    import axi2hdmi_frame_sink_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [23:0] pix_i,
    output logic [31:0] crc_o
);

    function automatic logic [31:0] crc_pix(input logic [31:0] crc_in, input logic [23:0] pix);
        logic [31:0] c;
        c = crc_in;
        for (int b = 2; b >= 0; b--) begin
            c = c ^ {24'h0, pix[b*8 +: 8]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
            end
        end
        return c;
    endfunction

    assign crc_o = crc_pix(crc_i, pix_i);

endmodule
`endif

// File: rtl/axi2hdmi_frame_sink.sv
// Video sink: recovers raster timing from hsync/vsync and signs the active window per frame.
// Define AXI2HDMI_FRAME_SINK_CRC_EN for a CRC-32 signature; default build uses a 32-bit pixel sum.
module axi2hdmi_frame_sink
    import axi2hdmi_frame_sink_pkg::*;
#(
    parameter bit          SyncActiveHigh = 1'b1,
    parameter int unsigned CntWidth       = 16,
    parameter int unsigned HActStart      = 144,
    parameter int unsigned HActive        = 640,
    parameter int unsigned VActStart      = 35,
    parameter int unsigned VActive        = 480
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                pix_en_i,
    input  logic                hsync_i,
    input  logic                vsync_i,
    input  logic [7:0]          red_i,
    input  logic [7:0]          green_i,
    input  logic [7:0]          blue_i,
    input  logic                clear_i,
    output logic                frame_valid_o,
    output logic [31:0]         frame_sig_o,
    output logic [CntWidth-1:0] h_total_o,
    output logic [CntWidth-1:0] v_total_o,
    output logic [CntWidth-1:0] frame_cnt_o,
    output logic                timing_err_o
);

    localparam logic [CntWidth-1:0] CNT_ONE = {{(CntWidth-1){1'b0}}, 1'b1};
    localparam logic [CntWidth-1:0] CNT_MAX = {CntWidth{1'b1}};
    localparam logic [CntWidth:0]   H_LO    = (CntWidth+1)'(HActStart);
    localparam logic [CntWidth:0]   H_HI    = (CntWidth+1)'(HActStart + HActive);
    localparam logic [CntWidth:0]   V_LO    = (CntWidth+1)'(VActStart);
    localparam logic [CntWidth:0]   V_HI    = (CntWidth+1)'(VActStart + VActive);

`ifdef AXI2HDMI_FRAME_SINK_CRC_EN
    localparam logic [31:0] SIG_INIT = CRC_INIT;
    localparam logic [31:0] SIG_XOR  = CRC_XOROUT;
`else
    localparam logic [31:0] SIG_INIT = 32'h0;
    localparam logic [31:0] SIG_XOR  = 32'h0;
`endif

    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    state_e              state_q, state_d;
    logic                hs_prev_q, vs_prev_q, line_seen_q, h_ref_vld_q;
    logic [CntWidth-1:0] h_cnt_q, v_cnt_q, h_last_q;
    logic [31:0]         sig_q;

    logic                hs_on, vs_on, hs_edge, vs_edge, hs_cap, in_win, accum, report;
    logic                h_err, v_err, sat_err;
    logic [CntWidth-1:0] h_cnt_d, v_cnt_d, h_last_d, line_len, v_tot_now;
    logic [23:0]         pix;
    logic [31:0]         sig_base, sig_upd, sig_d;

    // Sync edge detection and raster counters
    assign hs_on     = (hsync_i == SyncActiveHigh);
    assign vs_on     = (vsync_i == SyncActiveHigh);
    assign hs_edge   = pix_en_i & hs_on & ~hs_prev_q;
    assign vs_edge   = pix_en_i & vs_on & ~vs_prev_q;
    assign h_cnt_d   = hs_edge ? '0 : sat_inc(h_cnt_q);
    assign v_cnt_d   = vs_edge ? '0 : (hs_edge ? sat_inc(v_cnt_q) : v_cnt_q);
    assign line_len  = sat_inc(h_cnt_q);
    assign v_tot_now = sat_inc(v_cnt_q);
    // The first edge after reset closes a line of unknown start, so it is not measured.
    assign hs_cap    = hs_edge & line_seen_q;
    assign h_last_d  = hs_cap ? line_len : h_last_q;

    assign in_win = ({1'b0, h_cnt_d} >= H_LO) && ({1'b0, h_cnt_d} < H_HI) &&
                    ({1'b0, v_cnt_d} >= V_LO) && ({1'b0, v_cnt_d} < V_HI);

    assign h_err   = hs_cap & h_ref_vld_q & (line_len != h_last_q);
    assign v_err   = report & (state_q == RUN) & (v_tot_now != v_total_o);
    assign sat_err = pix_en_i & ((h_cnt_d == CNT_MAX) | (v_cnt_d == CNT_MAX));

    // Signature datapath: a vsync edge restarts it with the edge pixel included
    assign pix      = {red_i, green_i, blue_i};
    assign sig_base = vs_edge ? SIG_INIT : sig_q;
    assign accum    = in_win & (vs_edge | (state_q != IDLE));
    assign sig_d    = accum ? sig_upd : sig_base;

`ifdef AXI2HDMI_FRAME_SINK_CRC_EN
    axi2hdmi_frame_sink_crc24 u_crc24 (
        .crc_i (sig_base),
        .pix_i (pix),
        .crc_o (sig_upd)
    );
`else
    assign sig_upd = sig_base + {8'h00, pix};
`endif

    always_comb begin
        state_d = state_q;
        report  = 1'b0;
        if (vs_edge) begin
            case (state_q)
                IDLE:    state_d = FIRST;
                FIRST: begin
                    state_d = RUN;
                    report  = 1'b1;
                end
                default: begin
                    state_d = RUN;
                    report  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            line_seen_q   <= 1'b0;
            h_ref_vld_q   <= 1'b0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            h_last_q      <= '0;
            sig_q         <= SIG_INIT;
            frame_valid_o <= 1'b0;
            frame_sig_o   <= '0;
            h_total_o     <= '0;
            v_total_o     <= '0;
            frame_cnt_o   <= '0;
            timing_err_o  <= 1'b0;
        end else if (clear_i) begin
            state_q       <= IDLE;
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            line_seen_q   <= 1'b0;
            h_ref_vld_q   <= 1'b0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            h_last_q      <= '0;
            sig_q         <= SIG_INIT;
            frame_valid_o <= 1'b0;
            frame_sig_o   <= '0;
            h_total_o     <= '0;
            v_total_o     <= '0;
            frame_cnt_o   <= '0;
            timing_err_o  <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_valid_o <= report;
            if (pix_en_i) begin
                hs_prev_q <= hs_on;
                vs_prev_q <= vs_on;
                h_cnt_q   <= h_cnt_d;
                v_cnt_q   <= v_cnt_d;
                h_last_q  <= h_last_d;
                sig_q     <= sig_d;
                if (hs_edge) line_seen_q <= 1'b1;
                if (vs_edge)     h_ref_vld_q <= 1'b0;
                else if (hs_cap) h_ref_vld_q <= 1'b1;
            end
            // Report stage: results of the frame that just closed
            if (report) begin
                frame_sig_o <= sig_q ^ SIG_XOR;
                h_total_o   <= h_last_d;
                v_total_o   <= v_tot_now;
                frame_cnt_o <= frame_cnt_o + CNT_ONE;
            end
            if (h_err | v_err | sat_err) timing_err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi2hdmi_frame_sink.sv
// Randomized bench for axi2hdmi_frame_sink: three instances (active-high, active-low, 1-pixel window)
// fed one raster, checked against a frame-level reference model.
module tb_axi2hdmi_frame_sink;

    localparam int H_START = 2;
    localparam int V_START = 1;
    localparam int V_ACT   = 1;

`ifdef AXI2HDMI_FRAME_SINK_CRC_EN
    localparam logic [31:0] EXP_DIR  = 32'hCBF4_3926;
    localparam logic [31:0] EXP_ZERO = 32'hFF41_D912;
`else
    localparam logic [31:0] EXP_DIR  = 32'h009C_9FA2;
    localparam logic [31:0] EXP_ZERO = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        rst_n, pix_en, hs, vs, clear;
    logic        hs_b, vs_b;
    logic [7:0]  r, g, b;

    logic        fv_a, fv_b, fv_c, err_a, err_b, err_c;
    logic [31:0] sig_a, sig_b, sig_c;
    logic [15:0] ht_a, vt_a, fc_a, ht_b, vt_b, fc_b, ht_c, vt_c, fc_c;

    assign hs_b = ~hs;
    assign vs_b = ~vs;

    always #5 clk = ~clk;

    axi2hdmi_frame_sink #(.SyncActiveHigh(1'b1), .CntWidth(16), .HActStart(2), .HActive(3),
                          .VActStart(1), .VActive(1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .pix_en_i(pix_en), .hsync_i(hs), .vsync_i(vs),
        .red_i(r), .green_i(g), .blue_i(b), .clear_i(clear),
        .frame_valid_o(fv_a), .frame_sig_o(sig_a), .h_total_o(ht_a), .v_total_o(vt_a),
        .frame_cnt_o(fc_a), .timing_err_o(err_a));

    axi2hdmi_frame_sink #(.SyncActiveHigh(1'b0), .CntWidth(16), .HActStart(2), .HActive(3),
                          .VActStart(1), .VActive(1)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .pix_en_i(pix_en), .hsync_i(hs_b), .vsync_i(vs_b),
        .red_i(r), .green_i(g), .blue_i(b), .clear_i(clear),
        .frame_valid_o(fv_b), .frame_sig_o(sig_b), .h_total_o(ht_b), .v_total_o(vt_b),
        .frame_cnt_o(fc_b), .timing_err_o(err_b));

    axi2hdmi_frame_sink #(.SyncActiveHigh(1'b1), .CntWidth(16), .HActStart(2), .HActive(1),
                          .VActStart(1), .VActive(1)) dut_c (
        .clk_i(clk), .rst_ni(rst_n), .pix_en_i(pix_en), .hsync_i(hs), .vsync_i(vs),
        .red_i(r), .green_i(g), .blue_i(b), .clear_i(clear),
        .frame_valid_o(fv_c), .frame_sig_o(sig_c), .h_total_o(ht_c), .v_total_o(vt_c),
        .frame_cnt_o(fc_c), .timing_err_o(err_c));

    int n_vec = 0;
    int n_err = 0;

    // Frame raster: 4 lines, 8 samples each (9 for a stretched line)
    logic [23:0] fpix [4][10];
    int          flen [4];

    int          edges, reports, gap_mode;
    int          exp_ht, exp_vt, last_vt;
    logic [31:0] exp_sig_a, exp_sig_c;
    bit          exp_err, chk_low;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_sig(input int hlo, input int hhi);
        logic [7:0]  bytes [$];
        logic [23:0] p;
        logic [31:0] acc;
        for (int l = 0; l < 4; l++)
            for (int h = 0; h < flen[l]; h++)
                if (l >= V_START && l < V_START + V_ACT && h >= hlo && h < hhi) begin
                    p = fpix[l][h];
                    bytes.push_back(p[23:16]);
                    bytes.push_back(p[15:8]);
                    bytes.push_back(p[7:0]);
                end
`ifdef AXI2HDMI_FRAME_SINK_CRC_EN
        acc = 32'hFFFF_FFFF;
        foreach (bytes[i]) begin
            acc = acc ^ {24'h0, bytes[i]};
            repeat (8) acc = acc[0] ? ((acc >> 1) ^ 32'hEDB8_8320) : (acc >> 1);
        end
        return ~acc;
`else
        acc = 32'h0;
        for (int i = 0; i < bytes.size(); i += 3)
            acc = acc + {8'h00, bytes[i], bytes[i+1], bytes[i+2]};
        return acc;
`endif
    endfunction

    task automatic low_check();
        if (chk_low) begin
            check("fv_one_cycle_a", {31'h0, fv_a}, 32'h0);
            check("fv_one_cycle_b", {31'h0, fv_b}, 32'h0);
            chk_low = 1'b0;
        end
    endtask

    task automatic model_clear();
        edges   = 0;
        reports = 0;
        exp_err = 1'b0;
        chk_low = 1'b0;
    endtask

    task automatic drive_sample(input logic hsv, input logic vsv, input logic [23:0] pixv);
        hs = hsv; vs = vsv; {r, g, b} = pixv; pix_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        low_check();
    endtask

    task automatic idle_gap();
        int n;
        n = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
        repeat (n) begin
            pix_en = 1'b0;
            hs = 1'($urandom); vs = 1'($urandom);
            {r, g, b} = 24'($urandom);
            @(posedge clk);
            @(negedge clk);
            low_check();
        end
    endtask

    task automatic frame_start_checks();
        if (edges >= 1) begin
            if (reports >= 1 && exp_vt != last_vt) exp_err = 1'b1;
            reports++;
            last_vt = exp_vt;
            check("fv_a", {31'h0, fv_a}, 32'h1);
            check("fv_b", {31'h0, fv_b}, 32'h1);
            check("fv_c", {31'h0, fv_c}, 32'h1);
            check("sig_a", sig_a, exp_sig_a);
            check("sig_b", sig_b, exp_sig_a);
            check("sig_c", sig_c, exp_sig_c);
            check("h_total", {16'h0, ht_a}, 32'(exp_ht));
            check("v_total", {16'h0, vt_a}, 32'(exp_vt));
            check("frame_cnt", {16'h0, fc_a}, 32'(reports & 16'hFFFF));
            check("frame_cnt_b", {16'h0, fc_b}, 32'(reports & 16'hFFFF));
        end else begin
            check("fv_silent_a", {31'h0, fv_a}, 32'h0);
            check("fv_silent_b", {31'h0, fv_b}, 32'h0);
        end
        check("timing_err_a", {31'h0, err_a}, {31'h0, exp_err});
        check("timing_err_b", {31'h0, err_b}, {31'h0, exp_err});
        edges++;
        chk_low = 1'b1;
    endtask

    // kind 0: random, 1: "123456789" pixels, 2: zero active pixels; nl < 4 leaves the frame partial
    task automatic drive_frame(input int kind, input int stretch, input int nl);
        for (int l = 0; l < 4; l++) begin
            flen[l] = (l == stretch) ? 9 : 8;
            for (int h = 0; h < 10; h++) fpix[l][h] = 24'($urandom);
        end
        if (kind == 1) begin
            fpix[1][2] = 24'h313233;
            fpix[1][3] = 24'h343536;
            fpix[1][4] = 24'h373839;
        end else if (kind == 2) begin
            for (int h = 2; h < 5; h++) fpix[1][h] = 24'h0;
        end
        for (int l = 0; l < nl; l++)
            for (int h = 0; h < flen[l]; h++) begin
                drive_sample(h < 2, l == 0, fpix[l][h]);
                if (l == 0 && h == 0) frame_start_checks();
                idle_gap();
            end
        if (nl == 4) begin
            exp_sig_a = ref_sig(H_START, H_START + 3);
            exp_sig_c = ref_sig(H_START, H_START + 1);
            exp_ht    = flen[3];
            exp_vt    = 4;
            for (int l = 1; l < 4; l++)
                if (flen[l] != flen[l-1]) exp_err = 1'b1;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_fv"},  {31'h0, fv_a}, 32'h0);
        check({tag, "_sig"}, sig_a, 32'h0);
        check({tag, "_ht"},  {16'h0, ht_a}, 32'h0);
        check({tag, "_vt"},  {16'h0, vt_a}, 32'h0);
        check({tag, "_fc"},  {16'h0, fc_a}, 32'h0);
        check({tag, "_err"}, {31'h0, err_a}, 32'h0);
        check({tag, "_fc_b"}, {16'h0, fc_b}, 32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; pix_en = 1'b0; hs = 1'b0; vs = 1'b0; {r, g, b} = 24'h0;
        gap_mode = 0; exp_ht = 0; exp_vt = 0; last_vt = 0; exp_sig_a = 0; exp_sig_c = 0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed frames with pix_en tied high
        drive_frame(1, -1, 4);
        drive_frame(2, -1, 4);
        check("sig_dir_const", sig_a, EXP_DIR);
        check("h_total_const", {16'h0, ht_a}, 32'd8);
        check("v_total_const", {16'h0, vt_a}, 32'd4);
        drive_frame(0, -1, 4);
        check("sig_1px_zero_const", sig_c, EXP_ZERO);
        drive_frame(0, -1, 4);

        // Stretched line, then clean frames: the error is sticky
        gap_mode = 2;
        drive_frame(0, 2, 4);
        drive_frame(0, -1, 4);
        drive_frame(0, -1, 4);
        drive_frame(0, -1, 4);
        check("err_sticky", {31'h0, err_a}, 32'h1);

        // Soft clear, then alternating pix_en on the same raster
        clear = 1'b1; pix_en = 1'b0; hs = 1'b0; vs = 1'b0;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        check_zero("clear");
        model_clear();
        gap_mode = 1;
        drive_frame(1, -1, 4);
        drive_frame(0, -1, 4);
        check("sig_b_dir_const", sig_b, EXP_DIR);
        drive_frame(0, -1, 4);

        // Reset in the middle of a frame
        gap_mode = 0;
        drive_frame(0, -1, 2);
        pix_en = 1'b0; hs = 1'b0; vs = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        drive_frame(0, -1, 4);
        drive_frame(0, -1, 4);
        drive_frame(0, -1, 4);

        gap_mode = 2;
        for (int i = 0; i < 4; i++) drive_frame(0, -1, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
